// File: rtl/msg_uart_tx.sv
// ============================================================================
// msg_uart_tx : sends the first len characters of a writable buffer over UART
// Rev 1.0
// ============================================================================
`default_nettype none

module msg_uart_tx #(
  parameter int CLOCKS_PER_BIT = 10,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int MAX_LEN        = 16,
  parameter int ADDR_W         = $clog2(MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_W:0]      len,
  input  logic                 trigger,
  input  logic                 abort,
  output logic                 sending,
  output logic                 tx,
  output logic [DATA_BITS-1:0] data,
  output logic                 done
);

  localparam int CNT_W = $clog2(STOP_BITS * CLOCKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * CLOCKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]    char_idx_q, char_idx_d;
  logic [ADDR_W:0]      len_q, len_d;
  logic                 tx_q, tx_d;
  logic                 sending_q, sending_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  logic [DATA_BITS-1:0] mem_q [MAX_LEN];

  logic [ADDR_W-1:0]    idx_nxt;
  logic [ADDR_W:0]      idx_inc;
  logic [BIT_W-1:0]     bit_nxt;
  logic                 par_bit;
  logic                 bit_end;

  assign idx_nxt = char_idx_q + ADDR_W'(1);
  assign idx_inc = {1'b0, char_idx_q} + (ADDR_W+1)'(1);
  assign bit_nxt = bit_cnt_q + BIT_W'(1);
  assign bit_end = (clk_cnt_q == BIT_END);
  assign par_bit = (PARITY == 1) ? ~(^data_q) : (^data_q);

  // Buffer is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE)
      mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    char_idx_d = char_idx_q;
    len_d      = len_q;
    tx_d       = tx_q;
    sending_d  = sending_q;
    done_d     = 1'b0;
    data_d     = data_q;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        tx_d      = 1'b1;
        sending_d = 1'b0;
        if (trigger && !abort) begin
          if (len != '0) begin
            state_d    = S_START;
            len_d      = len;
            char_idx_d = '0;
            sending_d  = 1'b1;
            tx_d       = 1'b0;
            data_d     = mem_q[ADDR_W'(0)];
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = S_DATA;
          tx_d      = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = par_bit;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_nxt;
            tx_d      = data_q[bit_nxt];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_STOP;
          tx_d      = 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == STOP_END) begin
          clk_cnt_d = '0;
          // Next character starts straight out of the stop bit, no idle gap.
          if (idx_inc < len_q) begin
            char_idx_d = idx_nxt;
            data_d     = mem_q[idx_nxt];
            state_d    = S_START;
            tx_d       = 1'b0;
          end else begin
            state_d   = S_IDLE;
            sending_d = 1'b0;
            done_d    = 1'b1;
            tx_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        tx_d      = 1'b1;
        sending_d = 1'b0;
      end
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      tx_d      = 1'b1;
      sending_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      char_idx_q <= '0;
      len_q      <= '0;
      tx_q       <= 1'b1;
      sending_q  <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      char_idx_q <= char_idx_d;
      len_q      <= len_d;
      tx_q       <= tx_d;
      sending_q  <= sending_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

  assign tx      = tx_q;
  assign sending = sending_q;
  assign done    = done_q;
  assign data    = data_q;

endmodule

`default_nettype wire
